// File: rtl/tx_axis_arbiter.sv
// Packet-granular round-robin arbiter feeding the single tx_mac AXIS input.
// The grant is locked from a frame's first beat through its tlast handshake.
module tx_axis_arb_lane #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_W     = DATA_WIDTH / 8
) (
   input  logic                  gnt,
   input  logic                  m_ready,
   input  logic [DATA_WIDTH-1:0] tdata,
   input  logic [KEEP_W-1:0]     tkeep,
   input  logic                  tvalid,
   input  logic                  tlast,
   output logic                  tready,
   output logic [DATA_WIDTH-1:0] sel_data,
   output logic [KEEP_W-1:0]     sel_keep,
   output logic                  sel_valid,
   output logic                  sel_last
);
   // Ungranted lanes contribute zeros so the top can OR-reduce.
   assign tready    = gnt & m_ready;
   assign sel_data  = gnt ? tdata : '0;
   assign sel_keep  = gnt ? tkeep : '0;
   assign sel_valid = gnt & tvalid;
   assign sel_last  = gnt & tlast;
endmodule

module tx_axis_arbiter #(
   parameter int N_PORTS    = 4,
   parameter int DATA_WIDTH = 64
) (
   input  logic                              i_clk,
   input  logic                              i_reset_n,
   input  logic [N_PORTS*DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [N_PORTS*DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [N_PORTS-1:0]                s_axis_tvalid,
   input  logic [N_PORTS-1:0]                s_axis_tlast,
   output logic [N_PORTS-1:0]                s_axis_tready,
   output logic [DATA_WIDTH-1:0]             m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic [N_PORTS-1:0]                o_grant,
   output logic                              o_busy
);
   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam int IDXW   = $clog2(N_PORTS);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                            state;
   logic [N_PORTS-1:0]                grant;
   logic [IDXW-1:0]                   last_grant;

   logic [N_PORTS-1:0][DATA_WIDTH-1:0] lane_tdata;
   logic [N_PORTS-1:0][KEEP_W-1:0]     lane_tkeep;
   logic [N_PORTS-1:0][DATA_WIDTH-1:0] sel_data;
   logic [N_PORTS-1:0][KEEP_W-1:0]     sel_keep;
   logic [N_PORTS-1:0]                 sel_valid;
   logic [N_PORTS-1:0]                 sel_last;
   logic [N_PORTS-1:0]                 gnt_act;

   logic [N_PORTS-1:0]                 pick_req;
   logic                               pick_found;
   logic [IDXW-1:0]                    pick_idx;
   logic                               eof;

   assign lane_tdata = s_axis_tdata;
   assign lane_tkeep = s_axis_tkeep;

   // Reset also quiets the datapath combinationally, so nothing handshakes
   // while i_reset_n is low even though the grant register clears a cycle later.
   assign gnt_act = grant & {N_PORTS{i_reset_n}};

   for (genvar k = 0; k < N_PORTS; k++) begin : g_lane
      tx_axis_arb_lane #(.DATA_WIDTH(DATA_WIDTH), .KEEP_W(KEEP_W)) u_lane (
         .gnt       (gnt_act[k]),
         .m_ready   (m_axis_tready),
         .tdata     (lane_tdata[k]),
         .tkeep     (lane_tkeep[k]),
         .tvalid    (s_axis_tvalid[k]),
         .tlast     (s_axis_tlast[k]),
         .tready    (s_axis_tready[k]),
         .sel_data  (sel_data[k]),
         .sel_keep  (sel_keep[k]),
         .sel_valid (sel_valid[k]),
         .sel_last  (sel_last[k])
      );
   end

   always_comb begin
      m_axis_tdata = '0;
      m_axis_tkeep = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         m_axis_tdata = m_axis_tdata | sel_data[k];
         m_axis_tkeep = m_axis_tkeep | sel_keep[k];
      end
   end

   assign m_axis_tvalid = |sel_valid;
   assign m_axis_tlast  = |sel_last;
   assign eof           = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // At end of frame the finishing port is masked out; it can win again
   // only from IDLE on a later cycle.
   assign pick_req = (state == IDLE) ? s_axis_tvalid : (s_axis_tvalid & ~grant);

   always_comb begin
      int p;
      pick_found = 1'b0;
      pick_idx   = last_grant;
      for (int i = 1; i <= N_PORTS; i++) begin
         p = (int'(last_grant) + i) % N_PORTS;
         if (!pick_found && pick_req[p]) begin
            pick_found = 1'b1;
            pick_idx   = IDXW'(p);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= IDXW'(N_PORTS - 1);
         o_busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state      <= BUSY;
                  grant      <= N_PORTS'(1) << pick_idx;
                  last_grant <= pick_idx;
                  o_busy     <= 1'b1;
               end
            end
            BUSY: begin
               if (eof) begin
                  if (pick_found) begin
                     grant      <= N_PORTS'(1) << pick_idx;
                     last_grant <= pick_idx;
                  end else begin
                     state  <= IDLE;
                     grant  <= '0;
                     o_busy <= 1'b0;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               grant  <= '0;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

   assign o_grant = grant;

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Directed bench for tx_axis_arbiter (4 ports, 64-bit data).
module tb_tx_axis_arbiter;
   localparam int NP = 4;
   localparam int DW = 64;
   localparam int KW = DW / 8;

   logic              clk, rst_n;
   logic [NP*DW-1:0]  s_tdata;
   logic [NP*KW-1:0]  s_tkeep;
   logic [NP-1:0]     s_tvalid, s_tlast, s_tready;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tkeep;
   logic              m_tvalid, m_tlast, m_tready;
   logic [NP-1:0]     grant;
   logic              busy;

   int tests = 0;
   int fails = 0;

   tx_axis_arbiter #(.N_PORTS(NP), .DATA_WIDTH(DW)) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .o_grant       (grant),
      .o_busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] beat(input int p, input int b);
      return 64'h00D0_0000_0000_0000 | (64'(p) << 8) | 64'(b);
   endfunction

   task automatic drive(input int p, input logic v, input logic l,
                        input logic [63:0] d, input logic [7:0] k);
      s_tvalid[p]       = v;
      s_tlast[p]        = l;
      s_tdata[p*DW +: DW] = d;
      s_tkeep[p*KW +: KW] = k;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Settles the combinational path, then checks the control outputs.
   task automatic look(input string tag, input logic [3:0] g, input logic b,
                       input logic v, input logic [3:0] rdy);
      #1;
      chk({tag, ".grant"},  64'(grant),    64'(g));
      chk({tag, ".busy"},   64'(busy),     64'(b));
      chk({tag, ".mvalid"}, 64'(m_tvalid), 64'(v));
      chk({tag, ".tready"}, 64'(s_tready), 64'(rdy));
   endtask

   task automatic look_data(input string tag, input logic [63:0] d,
                            input logic [7:0] k, input logic l);
      chk({tag, ".data"}, m_tdata,        d);
      chk({tag, ".keep"}, 64'(m_tkeep),   64'(k));
      chk({tag, ".last"}, 64'(m_tlast),   64'(l));
   endtask

   initial begin
      int order3 [7];
      logic rdy_seq [7];
      int bb, acc, beats;
      order3  = '{0, 3, 0, 3, 0, 1, 3};
      rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0; m_tready = 1'b1;
      s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0;

      // Reset: a requester is present but nothing may move.
      @(negedge clk);
      drive(0, 1, 0, beat(0, 0), 8'hFF);
      look("rst", 4'b0000, 0, 0, 4'b0000);
      @(negedge clk);
      drive(0, 0, 0, 64'h0, 8'h00);
      rst_n = 1'b1;

      // Single source, port 2, three beats.
      drive(2, 1, 0, beat(2, 0), 8'hFF);
      look("t1.idle", 4'b0000, 0, 0, 4'b0000);
      @(negedge clk);
      look("t1.b0", 4'b0100, 1, 1, 4'b0100); look_data("t1.b0", beat(2, 0), 8'hFF, 0);
      @(negedge clk);
      drive(2, 1, 0, beat(2, 1), 8'hFF);
      look("t1.b1", 4'b0100, 1, 1, 4'b0100); look_data("t1.b1", beat(2, 1), 8'hFF, 0);
      @(negedge clk);
      drive(2, 1, 1, beat(2, 2), 8'h0F);
      look("t1.b2", 4'b0100, 1, 1, 4'b0100); look_data("t1.b2", beat(2, 2), 8'h0F, 1);
      @(negedge clk);
      drive(2, 0, 0, 64'h0, 8'h00);
      look("t1.end", 4'b0000, 0, 0, 4'b0000);

      // Contention right after reset: 0,1,2,3 back to back.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int p = 0; p < NP; p++) drive(p, 1, 0, beat(p, 0), 8'hFF);
      look("t2.idle", 4'b0000, 0, 0, 4'b0000);
      beats = 0;
      for (int p = 0; p < NP; p++) begin
         for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            if (b == 1) drive(p, 1, 1, beat(p, 1), 8'hFF);
            else if (p > 0) drive(p - 1, 0, 0, 64'h0, 8'h00);
            look($sformatf("t2.p%0d.b%0d", p, b), 4'(1 << p), 1, 1, 4'(1 << p));
            look_data($sformatf("t2.p%0d.b%0d", p, b), beat(p, b), 8'hFF, 1'(b));
            if (m_tvalid && m_tready) beats++;
         end
      end
      @(negedge clk);
      drive(3, 0, 0, 64'h0, 8'h00);
      look("t2.end", 4'b0000, 0, 0, 4'b0000);
      chk("t2.beats", 64'(beats), 64'd8);

      // Fairness: 0 and 3 alternate; port 1 joins while 3 holds the grant.
      @(negedge clk);
      drive(0, 1, 1, beat(0, 0), 8'hFF);
      drive(3, 1, 1, beat(3, 0), 8'hFF);
      look("t3.idle", 4'b0000, 0, 0, 4'b0000);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i == 3) drive(1, 1, 1, beat(1, 0), 8'hFF);
         if (i == 6) begin
            drive(0, 0, 0, 64'h0, 8'h00);
            drive(1, 0, 0, 64'h0, 8'h00);
         end
         look($sformatf("t3.g%0d", i), 4'(1 << order3[i]), 1, 1, 4'(1 << order3[i]));
         look_data($sformatf("t3.g%0d", i), beat(order3[i], 0), 8'hFF, 1);
      end
      @(negedge clk);
      drive(3, 0, 0, 64'h0, 8'h00);
      look("t3.end", 4'b0000, 0, 0, 4'b0000);

      // Backpressure on a 4-beat frame from port 1, port 0 waiting.
      @(negedge clk);
      drive(1, 1, 0, beat(1, 0), 8'hFF);
      look("t4.idle", 4'b0000, 0, 0, 4'b0000);
      bb = 0; acc = 0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c == 0) drive(0, 1, 1, beat(0, 0), 8'hFF);
         m_tready = rdy_seq[c];
         drive(1, 1, 1'(bb == 3), beat(1, bb), (bb == 3) ? 8'h0F : 8'hFF);
         look($sformatf("t4.c%0d", c), 4'b0010, 1, 1, rdy_seq[c] ? 4'b0010 : 4'b0000);
         look_data($sformatf("t4.c%0d", c), beat(1, bb), (bb == 3) ? 8'h0F : 8'hFF, 1'(bb == 3));
         if (m_tvalid && s_tready[1]) acc++;
         if (rdy_seq[c]) bb++;
      end
      chk("t4.accepted", 64'(acc), 64'd4);
      @(negedge clk);
      m_tready = 1'b1;
      drive(1, 0, 0, 64'h0, 8'h00);
      look("t4.p0", 4'b0001, 1, 1, 4'b0001); look_data("t4.p0", beat(0, 0), 8'hFF, 1);
      @(negedge clk);
      drive(0, 0, 0, 64'h0, 8'h00);
      look("t4.end", 4'b0000, 0, 0, 4'b0000);

      // Source gap on port 1 while port 2 waits.
      @(negedge clk);
      drive(1, 1, 0, beat(1, 0), 8'hFF);
      look("t5.idle", 4'b0000, 0, 0, 4'b0000);
      @(negedge clk);
      drive(2, 1, 1, beat(2, 0), 8'hFF);
      look("t5.b0", 4'b0010, 1, 1, 4'b0010); look_data("t5.b0", beat(1, 0), 8'hFF, 0);
      @(negedge clk);
      drive(1, 0, 0, 64'h0, 8'h00);
      look("t5.gap1", 4'b0010, 1, 0, 4'b0010);
      @(negedge clk);
      look("t5.gap2", 4'b0010, 1, 0, 4'b0010);
      @(negedge clk);
      drive(1, 1, 0, beat(1, 1), 8'hFF);
      look("t5.b1", 4'b0010, 1, 1, 4'b0010); look_data("t5.b1", beat(1, 1), 8'hFF, 0);
      @(negedge clk);
      drive(1, 1, 1, beat(1, 2), 8'h0F);
      look("t5.b2", 4'b0010, 1, 1, 4'b0010); look_data("t5.b2", beat(1, 2), 8'h0F, 1);
      @(negedge clk);
      drive(1, 0, 0, 64'h0, 8'h00);
      look("t5.p2", 4'b0100, 1, 1, 4'b0100); look_data("t5.p2", beat(2, 0), 8'hFF, 1);
      @(negedge clk);
      drive(2, 0, 0, 64'h0, 8'h00);
      look("t5.end", 4'b0000, 0, 0, 4'b0000);

      // Reset during beat 2 of a 5-beat frame from port 0.
      @(negedge clk);
      drive(0, 1, 0, beat(0, 0), 8'hFF);
      look("t6.idle", 4'b0000, 0, 0, 4'b0000);
      @(negedge clk);
      look("t6.b0", 4'b0001, 1, 1, 4'b0001);
      @(negedge clk);
      drive(0, 1, 0, beat(0, 1), 8'hFF);
      rst_n = 1'b0;
      look("t6.inrst", 4'b0001, 1, 0, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1, 0, beat(0, 0), 8'hFF);
      drive(3, 1, 0, beat(3, 0), 8'hFF);
      look("t6.after", 4'b0000, 0, 0, 4'b0000);
      @(negedge clk);
      look("t6.prio", 4'b0001, 1, 1, 4'b0001); look_data("t6.prio", beat(0, 0), 8'hFF, 0);

      @(negedge clk);
      s_tvalid = '0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
